// File: rtl/pc_pkg.sv
// Shared types and constants for the rv32 program-counter / fetch stage.
package pc_pkg;

  // Fetch stage sequencing
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_TRAP  = 2'd2
  } fetch_state_t;

  // Conditional-branch funct3 encodings
  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } bcond_t;

  // Sequential instruction stride in bytes
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_fetch_branch_cond.sv
// Branch resolution from the ALU SUB flags and operand sign bits.
// Signed/unsigned less-than are rebuilt from N plus the operand MSBs so the
// ALU does not need to export a carry or overflow flag.
module branch_cond
  import pc_pkg::*;
(
  input  logic [2:0] bcond,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       a_msb,
  input  logic       b_msb,
  output logic       taken
);

  logic   ovf;
  logic   lt;
  logic   ltu;
  bcond_t sel;

  assign sel = bcond_t'(bcond);

  // Decode funct3 into a taken decision; reserved encodings never branch
  always_comb begin
    ovf   = (a_msb != b_msb) && (alu_n != a_msb);
    lt    = alu_n ^ ovf;
    ltu   = (a_msb == b_msb) ? alu_n : b_msb;
    taken = 1'b0;
    case (sel)
      BEQ:     taken = alu_z;
      BNE:     taken = !alu_z;
      BLT:     taken = lt;
      BGE:     taken = !lt;
      BLTU:    taken = ltu;
      BGEU:    taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch for the non-pipelined rv32 core.
// Fetches one word over req/ack, holds it for execute, then resolves the
// next PC from the ALU outputs (branch / JAL / JALR).
// Optional build macro: PC_MISALIGN_TRAP_EN -- a next PC with bit 1 set parks
// the stage in S_TRAP (pc_misalign high) instead of being loaded; without it
// the low two bits of the next PC are cleared.
module pc_fetch
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        jump,
  input  logic        jalr,
  input  logic [2:0]  bcond,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        a_msb,
  input  logic        b_msb,
  input  logic [31:0] alu_result,
  input  logic [31:0] imm,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        pc_misalign,
`endif
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;

  logic         taken;
  logic [31:0]  rel_target;
  logic [31:0]  jalr_target;
  logic [31:0]  next_pc_raw;
  logic [31:0]  next_pc;
  logic         misalign;

  branch_cond u_branch_cond (
    .bcond (bcond),
    .alu_z (alu_z),
    .alu_n (alu_n),
    .a_msb (a_msb),
    .b_msb (b_msb),
    .taken (taken)
  );

  // Next-PC selection: jalr beats jump beats a taken branch; all adds wrap
  always_comb begin
    rel_target  = pc_q + imm;
    jalr_target = alu_result & ~32'd1;
    if (jalr) begin
      next_pc_raw = jalr_target;
    end else if (jump) begin
      next_pc_raw = rel_target;
    end else if (branch && taken) begin
      next_pc_raw = rel_target;
    end else begin
      next_pc_raw = pc_q + PC_STEP;
    end
`ifdef PC_MISALIGN_TRAP_EN
    next_pc  = next_pc_raw;
    misalign = next_pc_raw[1];
`else
    next_pc  = next_pc_raw & ~32'd3;
    misalign = 1'b0;
`endif
  end

  // Fetch/execute sequencing; ack is only meaningful in S_FETCH and
  // exec_done only in S_EXEC
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          if (misalign) begin
            // Faulting instruction's address stays in pc for the handler
            state_d = S_TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      S_TRAP: begin
        state_d = S_TRAP;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers; reset overrides any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Outputs decode the registered state; the request is masked during reset
  assign imem_req    = (state_q == S_FETCH) && !rst;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_EXEC);
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + PC_STEP;
`ifdef PC_MISALIGN_TRAP_EN
  assign pc_misalign = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed scoreboard bench for pc_fetch. Stimulus queues expected fetch
// addresses and instruction words; a negedge monitor checks them whenever
// imem_req or instr_valid rises.
module tb_pc_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        jalr = 1'b0;
  logic [2:0]  bcond = 3'b000;
  logic        alu_z = 1'b0;
  logic        alu_n = 1'b0;
  logic        a_msb = 1'b0;
  logic        b_msb = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] imm = 32'd0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
  logic        pc_misalign;
`endif

  int passes = 0;
  int total  = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_ipc_q[$];
  logic [31:0] exp_instr_q[$];

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .branch(branch), .jump(jump), .jalr(jalr),
    .bcond(bcond), .alu_z(alu_z), .alu_n(alu_n),
    .a_msb(a_msb), .b_msb(b_msb),
    .alu_result(alu_result), .imm(imm),
`ifdef PC_MISALIGN_TRAP_EN
    .pc_misalign(pc_misalign),
`endif
    .pc(pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one line per observed transaction, compared to the scoreboard
  logic        prev_req = 1'b0;
  logic        prev_iv  = 1'b0;
  logic [31:0] m_addr, m_pc, m_instr;
  always @(negedge clk) begin
    if (imem_req && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        chk(1'b0, "unexpected_fetch", imem_addr, 32'd0);
      end else begin
        m_addr = exp_addr_q.pop_front();
        $display("fetch req addr=%h exp=%h", imem_addr, m_addr);
        chk(imem_addr == m_addr, "fetch_addr", imem_addr, m_addr);
      end
    end
    if (instr_valid && !prev_iv) begin
      if (exp_instr_q.size() == 0) begin
        chk(1'b0, "unexpected_instr", instr, 32'd0);
      end else begin
        m_pc    = exp_ipc_q.pop_front();
        m_instr = exp_instr_q.pop_front();
        $display("instr pc=%h instr=%h exp_pc=%h exp_instr=%h", pc, instr, m_pc, m_instr);
        chk(instr == m_instr, "instr_word", instr, m_instr);
        chk(pc == m_pc, "instr_pc", pc, m_pc);
      end
    end
    prev_req = imem_req;
    prev_iv  = instr_valid;
  end

  // Wait for the request, hold it wt cycles, then ack (optionally with rst)
  task automatic fetch(input logic [31:0] rdata, input int wt,
                       input bit rst_on_ack, input logic [31:0] exp_pc);
    int n = 0;
    while (!imem_req && n < 40) begin
      tick();
      n++;
    end
    chk(imem_req == 1'b1, "req_timeout", {31'd0, imem_req}, 32'd1);
    if (!rst_on_ack) begin
      exp_ipc_q.push_back(exp_pc);
      exp_instr_q.push_back(rdata);
    end
    repeat (wt) tick();
    chk(imem_req == 1'b1 && imem_addr == exp_pc, "req_held", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    if (rst_on_ack) begin
      exp_addr_q.push_back(RST_PC);
      rst = 1'b1;
    end
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    if (rst_on_ack) begin
      chk(instr_valid == 1'b0, "rst_ack_iv", {31'd0, instr_valid}, 32'd0);
      chk(pc == RST_PC, "rst_ack_pc", pc, RST_PC);
      chk(imem_req == 1'b0, "rst_ack_req_low", {31'd0, imem_req}, 32'd0);
      rst = 1'b0;
    end else begin
      chk(instr_valid == 1'b1, "iv_after_ack", {31'd0, instr_valid}, 32'd1);
    end
  endtask

  // Pulse exec_done with the control inputs already set; check the new pc
  task automatic execute(input logic [31:0] exp_next, input bit expect_fetch,
                         input bit chk_p4, input logic [31:0] exp_p4);
    int n = 0;
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    chk(instr_valid == 1'b1, "exec_wait_timeout", {31'd0, instr_valid}, 32'd1);
    if (chk_p4) chk(pc_plus4 == exp_p4, "pc_plus4", pc_plus4, exp_p4);
    if (expect_fetch) exp_addr_q.push_back(exp_next);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    branch = 1'b0; jump = 1'b0; jalr = 1'b0;
    $display("exec done pc=%h exp=%h", pc, exp_next);
    chk(pc == exp_next, "next_pc", pc, exp_next);
  endtask

  task automatic set_br(input logic [2:0] bc, input logic z, input logic n,
                        input logic am, input logic bm, input logic [31:0] im);
    branch = 1'b1; bcond = bc; alu_z = z; alu_n = n;
    a_msb = am; b_msb = bm; imm = im;
  endtask

  initial begin
    exp_addr_q.push_back(RST_PC);
    repeat (3) tick();
    chk(pc == RST_PC, "reset_pc", pc, RST_PC);
    chk(instr == 32'd0, "reset_instr", instr, 32'd0);
    chk(instr_valid == 1'b0, "reset_iv", {31'd0, instr_valid}, 32'd0);
    chk(imem_req == 1'b0, "reset_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;

    // Plain fetch with 3 wait cycles, sequential next pc
    fetch(32'h00A00093, 3, 1'b0, 32'h100);
    execute(32'h104, 1'b1, 1'b1, 32'h104);
    // JAL to 0x200
    jump = 1'b1; imm = 32'h0000_00FC;
    fetch(32'h0FC0006F, 0, 1'b0, 32'h104);
    execute(32'h200, 1'b1, 1'b0, 32'd0);
    // BLT -1 < 1 taken backwards
    set_br(3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0);
    fetch(32'hFE20C8E3, 1, 1'b0, 32'h200);
    execute(32'h1F0, 1'b1, 1'b0, 32'd0);
    // JAL back to 0x200
    jump = 1'b1; imm = 32'h0000_0010;
    fetch(32'h0100006F, 0, 1'b0, 32'h1F0);
    execute(32'h200, 1'b1, 1'b0, 32'd0);
    // BLTU 0xFFFFFFFF < 1 not taken
    set_br(3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0);
    fetch(32'hFE20E8E3, 0, 1'b0, 32'h200);
    execute(32'h204, 1'b1, 1'b0, 32'd0);
    // BLT with signed overflow: 0x80000000 < 1 taken
    set_br(3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0020);
    fetch(32'h0220C063, 2, 1'b0, 32'h204);
    execute(32'h224, 1'b1, 1'b0, 32'd0);
    // BGE on the same operands not taken
    set_br(3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0020);
    fetch(32'h0220D063, 0, 1'b0, 32'h224);
    execute(32'h228, 1'b1, 1'b0, 32'd0);
    // BNE with Z=0 taken
    set_br(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
    fetch(32'h00209463, 0, 1'b0, 32'h228);
    execute(32'h230, 1'b1, 1'b0, 32'd0);
    // Reserved funct3 010 never taken even with Z=1
    set_br(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
    fetch(32'h0020A463, 0, 1'b0, 32'h230);
    execute(32'h234, 1'b1, 1'b0, 32'd0);
    // JALR and JAL together: jalr wins, bit 0 cleared
    jalr = 1'b1; jump = 1'b1; alu_result = 32'h0000_1235; imm = 32'h40;
    fetch(32'h000080E7, 0, 1'b0, 32'h234);
    execute(32'h1234, 1'b1, 1'b1, 32'h238);
    // JALR to the top word
    jalr = 1'b1; alu_result = 32'hFFFF_FFFC;
    fetch(32'h000080E7, 0, 1'b0, 32'h1234);
    execute(32'hFFFF_FFFC, 1'b1, 1'b0, 32'd0);
    // Sequential wrap to zero
    fetch(32'h00000013, 1, 1'b0, 32'hFFFF_FFFC);
    execute(32'h0, 1'b1, 1'b1, 32'h0);
    // JAL with imm=6 lands on a misaligned target
    jump = 1'b1; imm = 32'h0000_0006;
    fetch(32'h0060006F, 0, 1'b0, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
    execute(32'h0, 1'b0, 1'b0, 32'd0);
    chk(pc_misalign == 1'b1, "trap_flag", {31'd0, pc_misalign}, 32'd1);
    chk(imem_req == 1'b0, "trap_req", {31'd0, imem_req}, 32'd0);
    chk(instr_valid == 1'b0, "trap_iv", {31'd0, instr_valid}, 32'd0);
    exec_done = 1'b1;
    imem_ack  = 1'b1;
    repeat (3) tick();
    exec_done = 1'b0;
    imem_ack  = 1'b0;
    chk(pc_misalign == 1'b1 && pc == 32'h0, "trap_sticky", pc, 32'h0);
    exp_addr_q.push_back(RST_PC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(pc_misalign == 1'b0, "trap_exit", {31'd0, pc_misalign}, 32'd0);
    // Reset landing on the ack cycle drops the fetched word
    fetch(32'hDEAD_BEEF, 1, 1'b1, RST_PC);
`else
    execute(32'h4, 1'b1, 1'b0, 32'd0);
    // Reset landing on the ack cycle drops the fetched word
    fetch(32'hDEAD_BEEF, 1, 1'b1, 32'h4);
`endif
    // Normal operation resumes from RESET_PC
    fetch(32'h00100093, 2, 1'b0, RST_PC);
    execute(32'h104, 1'b1, 1'b0, 32'd0);
    repeat (4) tick();
    chk(exp_addr_q.size() == 0, "addr_queue_drained", exp_addr_q.size(), 32'd0);
    chk(exp_instr_q.size() == 0, "instr_queue_drained", exp_instr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
